// File: rtl/conv_encoder_param_if.sv
// Streaming bundle for conv_encoder_param: one information bit in, one N-bit code symbol out.
// master = bit source / symbol sink side, slave = encoder side.
interface conv_encoder_param_if #(
  parameter int N = 2
);
  logic         in_bit;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out_sym;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_bit, in_last, in_valid, out_ready,
    input  in_ready, out_sym, out_last, out_valid
  );

  modport slave (
    input  in_bit, in_last, in_valid, out_ready,
    output in_ready, out_sym, out_last, out_valid
  );
endinterface

// File: rtl/conv_encoder_param.sv
// Rate-1/N feed-forward convolutional encoder, constraint length K, generators G.
// `define CONV_ENC_ZERO_TAIL_EN for zero-tail frame termination; otherwise frames are truncated.

module conv_enc_parity #(
  parameter int             K    = 3,
  parameter logic [K-1:0]   TAPS = '1
) (
  input  logic [K-1:0] w_i,
  output logic         p_o
);
  assign p_o = ^(TAPS & w_i);
endmodule

module conv_encoder_param #(
  parameter int               K = 3,
  parameter int               N = 2,
  parameter logic [N*K-1:0]   G = 6'b111_101
) (
  input  logic               CLK,
  input  logic               RST_N,
  conv_encoder_param_if.slave bus
);
  logic [K-2:0] s_q, s_d;
  logic [N-1:0] sym_q, sym_d, par;
  logic         last_q, last_d;
  logic         vld_q, vld_d;
  logic         load, accept, step, cur;
  logic [K-1:0] w;

  // w[K-1] is the bit being encoded, w[0] the oldest remembered bit
  assign w = {cur, s_q};

  generate
    for (genvar j = 0; j < N; j++) begin : g_ch
      conv_enc_parity #(.K(K), .TAPS(G[j*K +: K])) u_par (.w_i(w), .p_o(par[j]));
    end
  endgenerate

  assign load   = !vld_q || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;

`ifdef CONV_ENC_ZERO_TAIL_EN
  localparam int CW = $clog2(K);
  typedef enum logic {RUN, TAIL} state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign bus.in_ready = RST_N && load && (state_q == RUN);
  assign cur          = (state_q == RUN) ? bus.in_bit : 1'b0;
  assign step         = (state_q == RUN) ? accept : load;
`else
  assign bus.in_ready = RST_N && load;
  assign cur          = bus.in_bit;
  assign step         = accept;
`endif

  always_comb begin
    s_d    = s_q;
    sym_d  = sym_q;
    last_d = last_q;
    vld_d  = vld_q && !bus.out_ready;
`ifdef CONV_ENC_ZERO_TAIL_EN
    state_d = state_q;
    cnt_d   = cnt_q;
`endif
    if (step) begin
      vld_d  = 1'b1;
      sym_d  = par;
      s_d    = {cur, s_q[K-2:1]};
      last_d = 1'b0;
`ifdef CONV_ENC_ZERO_TAIL_EN
      if (state_q == RUN) begin
        if (bus.in_last) begin
          state_d = TAIL;
          cnt_d   = CW'(K-1);
        end
      end else begin
        // K-1 zero shifts flush the memory, so s is zero when we return to RUN
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          last_d  = 1'b1;
          state_d = RUN;
        end
      end
`else
      if (bus.in_last) begin
        last_d = 1'b1;
        s_d    = '0;
      end
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s_q    <= '0;
      sym_q  <= '0;
      last_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      sym_q  <= sym_d;
      last_q <= last_d;
      vld_q  <= vld_d;
    end
  end

`ifdef CONV_ENC_ZERO_TAIL_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  assign bus.out_sym   = sym_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_conv_encoder_param.sv
// Bench for conv_encoder_param: random and directed frames against a shift-history parity model.
`timescale 1ns/1ps
module tb_conv_encoder_param;
  localparam int          KA = 3;
  localparam int          NA = 2;
  localparam logic [5:0]  GA = 6'b111_101;
  localparam int          KB = 4;
  localparam int          NB = 3;
  localparam logic [11:0] GB = {4'b1111, 4'b1101, 4'b1011};

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  conv_encoder_param_if #(.N(NA)) ia ();
  conv_encoder_param_if #(.N(NB)) ib ();

  conv_encoder_param #(.K(KA), .N(NA), .G(GA)) dut_a (.CLK(CLK), .RST_N(RST_N), .bus(ia));
  conv_encoder_param #(.K(KB), .N(NB), .G(GB)) dut_b (.CLK(CLK), .RST_N(RST_N), .bus(ib));

  int compared = 0;
  int mismatched = 0;
  int ready_mode = 0;

  logic [4:0]  exp_q[$];
  logic [15:0] hist_a = '0;
  int          log_sym[$];
  bit          log_last[$];
  int          logb_sym[$];
  bit          logb_last[$];
  bit          stall_prev = 0;
  logic [1:0]  held_sym;
  logic        held_last;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // h[d] is the input bit d transfers ago (h[0] = bit being encoded); generator bit i taps delay K-1-i
  function automatic logic [3:0] enc(input logic [15:0] h, input int k, input int n, input logic [15:0] g);
    logic [3:0] r;
    r = '0;
    for (int j = 0; j < n; j++)
      for (int i = 0; i < k; i++)
        if (g[j*k+i] && h[k-1-i]) r[j] = ~r[j];
    return r;
  endfunction

  task automatic model_accept(input logic b, input logic l);
    hist_a = {hist_a[14:0], b};
`ifdef CONV_ENC_ZERO_TAIL_EN
    exp_q.push_back({1'b0, enc(hist_a, KA, NA, 16'(GA))});
    if (l)
      for (int t = 1; t < KA; t++) begin
        hist_a = {hist_a[14:0], 1'b0};
        exp_q.push_back({(t == KA-1), enc(hist_a, KA, NA, 16'(GA))});
      end
`else
    exp_q.push_back({l, enc(hist_a, KA, NA, 16'(GA))});
    if (l) hist_a = '0;
`endif
  endtask

  // single compare process for DUT A, sampled mid-cycle while inputs and outputs are stable
  always @(negedge CLK) begin
    if (!RST_N) begin
      exp_q.delete();
      hist_a = '0;
      stall_prev = 0;
      check("rst_out_valid", ia.out_valid, 0);
      check("rst_out_sym", ia.out_sym, 0);
      check("rst_out_last", ia.out_last, 0);
      check("rst_in_ready", ia.in_ready, 0);
    end else begin
      if (stall_prev) begin
        check("hold_valid", ia.out_valid, 1);
        check("hold_sym", ia.out_sym, held_sym);
        check("hold_last", ia.out_last, held_last);
      end
      if (ia.out_valid && !ia.out_ready) check("bp_in_ready", ia.in_ready, 0);
      if (ia.out_valid) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_sym: got %0d, expected no symbol (t=%0t)", ia.out_sym, $time);
        end else begin
          check("sym", ia.out_sym, exp_q[0][3:0]);
          check("last", ia.out_last, exp_q[0][4]);
        end
        if (ia.out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          log_sym.push_back(ia.out_sym);
          log_last.push_back(ia.out_last);
        end
      end
      if (ia.in_valid && ia.in_ready) model_accept(ia.in_bit, ia.in_last);
      stall_prev = ia.out_valid && !ia.out_ready;
      held_sym = ia.out_sym;
      held_last = ia.out_last;
    end
  end

  always @(negedge CLK) begin
    if (RST_N && ib.out_valid && ib.out_ready) begin
      logb_sym.push_back(ib.out_sym);
      logb_last.push_back(ib.out_last);
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0: ia.out_ready = 1'b1;
        1: ia.out_ready = ~ia.out_ready;
        default: ia.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send_a(input logic b, input logic l, output int waits);
    ia.in_bit = b;
    ia.in_last = l;
    ia.in_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge CLK);
      #1;
      if (ia.in_ready) break;
      waits++;
      if (waits > 500) begin
        compared++;
        mismatched++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", waits);
        break;
      end
    end
    @(posedge CLK);
    #1;
    ia.in_valid = 1'b0;
  endtask

  task automatic send_frame_1011();
    int w;
    send_a(1, 0, w);
    send_a(0, 0, w);
    send_a(1, 0, w);
    send_a(1, 1, w);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ia.out_valid) && n < 300) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (n >= 300) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: %0d symbols still pending, expected 0", exp_q.size());
    end
  endtask

  task automatic check_seq(input string name, input int gs[$], input bit gl[$], input int es[$], input bit el[$]);
    check({name, "_len"}, gs.size(), es.size());
    for (int i = 0; i < es.size() && i < gs.size(); i++) begin
      check($sformatf("%s_sym%0d", name, i), gs[i], es[i]);
      check($sformatf("%s_last%0d", name, i), gl[i], el[i]);
    end
  endtask

  initial begin
    int w;
    int n;
    int wb;
    ia.in_bit = 0; ia.in_last = 0; ia.in_valid = 0; ia.out_ready = 1;
    ib.in_bit = 0; ib.in_last = 0; ib.in_valid = 0; ib.out_ready = 1;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;

    // K=4, N=3 instance: one-bit frame
    ib.in_bit = 1; ib.in_last = 1; ib.in_valid = 1;
    wb = 0;
    do begin
      @(negedge CLK);
      wb++;
    end while (!ib.in_ready && wb < 50);
    check("b_accept", ib.in_ready, 1);
    @(posedge CLK);
    #1 ib.in_valid = 0;
    repeat (8) @(posedge CLK);
    #1;
`ifdef CONV_ENC_ZERO_TAIL_EN
    check_seq("k4", logb_sym, logb_last, '{7, 6, 5, 7}, '{0, 0, 0, 1});
`else
    check_seq("k4", logb_sym, logb_last, '{7}, '{1});
`endif

    // full rate: 1011, then single-bit frame presented right after, then 1011
    ready_mode = 0;
    log_sym.delete(); log_last.delete();
    send_frame_1011();
    send_a(1, 1, w);
`ifdef CONV_ENC_ZERO_TAIL_EN
    check("tail_stall_cycles", w, KA-1);
`else
    check("tail_stall_cycles", w, 0);
`endif
    send_frame_1011();
    drain();
`ifdef CONV_ENC_ZERO_TAIL_EN
    check_seq("b2b", log_sym, log_last, '{3, 2, 0, 1, 1, 3, 3, 2, 3, 3, 2, 0, 1, 1, 3},
              '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1});
`else
    check_seq("b2b", log_sym, log_last, '{3, 2, 0, 1, 3, 3, 2, 0, 1}, '{0, 0, 0, 1, 1, 0, 0, 0, 1});
`endif

    // backpressure: out_ready toggles every cycle
    ready_mode = 1;
    log_sym.delete(); log_last.delete();
    send_frame_1011();
    drain();
`ifdef CONV_ENC_ZERO_TAIL_EN
    check_seq("bp", log_sym, log_last, '{3, 2, 0, 1, 1, 3}, '{0, 0, 0, 0, 0, 1});
`else
    check_seq("bp", log_sym, log_last, '{3, 2, 0, 1}, '{0, 0, 0, 1});
`endif

    // reset in the middle of the tail
    ready_mode = 0;
    repeat (2) @(posedge CLK);
    #1;
    log_sym.delete(); log_last.delete();
    send_frame_1011();
    n = 0;
`ifdef CONV_ENC_ZERO_TAIL_EN
    while (log_sym.size() < 5 && n < 50) begin @(negedge CLK); #1; n++; end
`else
    while (log_sym.size() < 3 && n < 50) begin @(negedge CLK); #1; n++; end
`endif
    @(posedge CLK);
    #1 RST_N = 1'b0;
    #1 check("midtail_rst_valid", ia.out_valid, 0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    log_sym.delete(); log_last.delete();
    send_a(1, 0, w);
    repeat (2) @(posedge CLK);
    #1;
    check("post_rst_len", log_sym.size(), 1);
    if (log_sym.size() != 0) check("post_rst_sym", log_sym[0], 3);
    send_a(0, 1, w);
    drain();

    // randomized frames, gaps and backpressure
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      send_a(1'($urandom_range(0, 1)), (i == 399) || ($urandom_range(0, 7) == 0), w);
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end
endmodule
